filt_sample_uart_tx: RTL and testbench
======================================

// Module: filt_sample_uart_tx
// PURPOSE
//   Streams filtered 8-bit sensor samples off-chip as an 8N1 UART byte stream for host logging/robot control.
//   Consumes the one-per-clock sample stream produced by the moving-average filter stage.
//   Keeps every DECIMATE-th valid sample, buffers it in a FIFO and serialises it, LSB first.
//   Sits between the filter output and the board TX pin.
// PARAMETERS
//   CLKS_PER_BIT  434  clock cycles per UART bit (50 MHz / 115200); legal >= 2
//   FIFO_DEPTH    16   sample FIFO entries; power of two, >= 2
//   DECIMATE      1    forward 1 of every DECIMATE valid samples; 1 = forward all
// PORTS
//   clk           in   1                      system clock
//   reset         in   1                      asynchronous, active-high reset
//   sample_in     in   8                      filtered sample
//   sample_valid  in   1                      sample_in valid this cycle
//   tx            out  1                      UART serial line, idle high
//   tx_busy       out  1                      high while a frame is on the line
//   frame_done    out  1                      1-cycle pulse, last cycle of stop bit
//   fifo_count    out  $clog2(FIFO_DEPTH)+1   entries currently buffered
//   overflow      out  1                      sticky: a forwarded sample was dropped
// BEHAVIOUR
//   Reset (async, immediate):
//     tx=1, tx_busy=0, frame_done=0, fifo_count=0, overflow=0.
//     FIFO pointers, decimation counter and FSM cleared (FSM -> IDLE).
//     A frame in flight is abandoned; no partial byte is resumed.
//   Decimation:
//     dec_cnt counts cycles with sample_valid=1, 0..DECIMATE-1, then wraps.
//     A sample is forwarded (push request) when sample_valid=1 and dec_cnt==0.
//     First valid sample after reset is always forwarded.
//   FIFO push:
//     Accepted if fifo_count<FIFO_DEPTH, or if a pop occurs in the same cycle.
//     Otherwise the sample is dropped and overflow is set; overflow stays set until reset.
//     Pointers wrap modulo FIFO_DEPTH.
//   FIFO pop:
//     Only when fifo_count>0 at the start of the cycle.
//     A push into an empty FIFO is poppable on the next cycle, never the same cycle.
//     fifo_count updates by +1, -1 or 0 (push+pop) per cycle.
//   FSM: IDLE -> START -> DATA -> STOP.
//     Each state holds its bit for exactly CLKS_PER_BIT cycles via baud counter.
//     IDLE:
//       tx=1, tx_busy=0.
//       If fifo_count>0: pop into shift reg; START entered next cycle.
//     START:
//       tx=0, tx_busy=1.
//     DATA:
//       tx=shift[0], then shift right; 8 bits, bit_idx 0..7, LSB first.
//     STOP:
//       tx=1.
//       frame_done=1 on its final cycle.
//       On that cycle, if fifo_count>0: pop and go to START (back-to-back, no idle gap).
//       Else go to IDLE.
//   Latency:
//     Push at cycle t into empty idle FIFO -> pop at t+1 -> tx falls at t+2.
//     Frame length 10*CLKS_PER_BIT cycles.
//     Back-to-back frames are contiguous.
//   tx is registered (glitch-free).
//   sample_valid while busy is buffered, never blocks; there is no backpressure port.
// TESTING (bench uses CLKS_PER_BIT=4, FIFO_DEPTH=4, DECIMATE=1 unless stated)
//   1) Single sample 8'hA5 -> tx low 2 cycles after push.
//      Bits sampled mid-bit: 0,1,0,1,0,0,1,0,1,1.
//      frame_done once at cycle 40 of frame; tx_busy high 40 cycles.
//   2) Push 8'h01,8'h80 on consecutive cycles -> two contiguous 40-cycle frames, no idle gap.
//      fifo_count sequence 1,1,0 around pops; frame_done twice.
//   3) 6 consecutive valid samples while idle:
//      - first popped, next 4 fill FIFO, sixth dropped -> overflow=1;
//      - exactly 5 frames sent (values 1..5 if inputs 1..6).
//   4) DECIMATE=3, samples 10..18 valid every cycle -> only 10,13,16 transmitted, in order.
//   5) Assert reset mid-DATA of frame 8'hFF with 2 entries queued:
//      - tx=1, fifo_count=0, tx_busy=0 immediately, overflow cleared;
//      - no frame after release until new push.
//   6) Full FIFO with pop and push same cycle (end of STOP) -> push accepted, overflow stays 0.

Source files
------------

// File: rtl/filt_sample_uart_tx_if.sv
// Sample-in / UART-out bundle for filt_sample_uart_tx; the DUT takes the slave view.
interface filt_sample_uart_tx_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    sample_in;
  logic          sample_valid;
  logic          tx;
  logic          tx_busy;
  logic          frame_done;
  logic [CW-1:0] fifo_count;
  logic          overflow;

  modport master (
    output sample_in, sample_valid,
    input  tx, tx_busy, frame_done, fifo_count, overflow
  );

  modport slave (
    input  sample_in, sample_valid,
    output tx, tx_busy, frame_done, fifo_count, overflow
  );
endinterface

// File: rtl/filt_sample_uart_tx.sv
// Decimates the filtered sample stream, buffers it and sends 8N1 UART frames; push->tx low in 2 cycles.
// No backpressure: samples arriving at a full FIFO without a same-cycle pop are dropped and flagged sticky.
module filt_sample_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16,
  parameter int DECIMATE     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  filt_sample_uart_tx_if.slave  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int DW = (DECIMATE > 1) ? $clog2(DECIMATE) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic [DW-1:0] dec_q, dec_d;
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  logic          overflow_q;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic push_req, push, pop, baud_last;

  assign push_req  = bus.sample_valid && (dec_q == '0);
  assign push      = push_req && ((count_q < CW'(FIFO_DEPTH)) || pop);
  assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));

  always_comb begin
    dec_d = dec_q;
    if (bus.sample_valid) begin
      dec_d = (dec_q == DW'(DECIMATE - 1)) ? '0 : dec_q + DW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dec_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      dec_q      <= dec_d;
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      count_q    <= count_q + CW'(push) - CW'(pop);
      overflow_q <= overflow_q | (push_req & ~push);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= bus.sample_in;
  end

  // Pop decisions use count_q, so a byte written this cycle is never read this cycle.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_q];
          state_d = START;
        end
      end
      START: begin
        baud_d = baud_q + BW'(1);
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        baud_d = baud_q + BW'(1);
        if (baud_last) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        baud_d = baud_q + BW'(1);
        if (baud_last) begin
          baud_d  = '0;
          state_d = IDLE;
          if (count_q != '0) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_q];
            state_d = START;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    tx_d = 1'b1;
    if (state_d == START)     tx_d = 1'b0;
    else if (state_d == DATA) tx_d = shift_d[0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  assign bus.tx         = tx_q;
  assign bus.tx_busy    = (state_q != IDLE);
  assign bus.frame_done = (state_q == STOP) && baud_last;
  assign bus.fifo_count = count_q;
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_filt_sample_uart_tx.sv
// Directed bench: two DUTs (DECIMATE 1 and 3), UART receivers feeding a byte scoreboard.
module tb_filt_sample_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  filt_sample_uart_tx_if #(.FIFO_DEPTH(DEPTH)) ifa ();
  filt_sample_uart_tx_if #(.FIFO_DEPTH(DEPTH)) ifb ();

  filt_sample_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .DECIMATE(1)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa)
  );
  filt_sample_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .DECIMATE(3)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb)
  );

  int         n_chk = 0;
  int         n_err = 0;
  int         cyc   = 0;
  int         fd_a  = 0;
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];
  int         start_a[$];
  bit         rx_act[2];
  int         rx_cnt[2];
  int         rx_st[2];
  logic [9:0] rx_bits[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic frame_end(input int u, input logic [9:0] bits, input int st);
    logic [7:0] e;
    chk(u == 0 ? "a_framing" : "b_framing", 32'({bits[9], bits[0]}), 32'(2'b10));
    if (u == 0) begin
      chk("a_frame_expected", 32'(exp_a.size() != 0), 32'd1);
      if (exp_a.size() != 0) begin
        e = exp_a.pop_front();
        chk("a_frame_data", 32'(bits[8:1]), 32'(e));
      end
      start_a.push_back(st);
    end else begin
      chk("b_frame_expected", 32'(exp_b.size() != 0), 32'd1);
      if (exp_b.size() != 0) begin
        e = exp_b.pop_front();
        chk("b_frame_data", 32'(bits[8:1]), 32'(e));
      end
    end
  endtask

  task automatic rx_tick(input int u, input logic txv);
    if (reset !== 1'b0) begin
      rx_act[u] = 1'b0;
    end else if (!rx_act[u]) begin
      if (txv === 1'b0) begin
        rx_act[u] = 1'b1;
        rx_cnt[u] = 0;
        rx_st[u]  = cyc;
      end
    end else begin
      rx_cnt[u]++;
      if (rx_cnt[u] % CPB == CPB / 2) begin
        rx_bits[u][rx_cnt[u] / CPB] = txv;
        if (rx_cnt[u] == 9 * CPB + CPB / 2) begin
          rx_act[u] = 1'b0;
          frame_end(u, rx_bits[u], rx_st[u]);
        end
      end
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (ifa.frame_done === 1'b1) fd_a++;
    rx_tick(0, ifa.tx);
    rx_tick(1, ifb.tx);
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic step_a(input logic [7:0] d);
    ifa.sample_in    = d;
    ifa.sample_valid = 1'b1;
    @(posedge clk);
    #1;
    ifa.sample_valid = 1'b0;
  endtask

  task automatic step_b(input logic [7:0] d);
    ifb.sample_in    = d;
    ifb.sample_valid = 1'b1;
    @(posedge clk);
    #1;
    ifb.sample_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input int max);
    int i = 0;
    while (i < max && (exp_a.size() != 0 || exp_b.size() != 0 || rx_act[0] || rx_act[1])) begin
      @(posedge clk);
      #1;
      i++;
    end
    chk(tag, 32'(exp_a.size() + exp_b.size()), 32'd0);
    idle(2 * CPB);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int bn, fn, fpos, fd0, low;
    reset            = 1'b1;
    ifa.sample_in    = '0;
    ifa.sample_valid = 1'b0;
    ifb.sample_in    = '0;
    ifb.sample_valid = 1'b0;
    idle(3);
    chk("rst_tx",       32'(ifa.tx),         32'd1);
    chk("rst_busy",     32'(ifa.tx_busy),    32'd0);
    chk("rst_fdone",    32'(ifa.frame_done), 32'd0);
    chk("rst_count",    32'(ifa.fifo_count), 32'd0);
    chk("rst_overflow", 32'(ifa.overflow),   32'd0);
    chk("rst_b_tx",     32'(ifb.tx),         32'd1);
    reset = 1'b0;
    idle(2);

    // 1) single byte: latency, busy length, frame_done position
    step_a(8'hA5);
    exp_a.push_back(8'hA5);
    chk("t1_tx_idle_after_push", 32'(ifa.tx),         32'd1);
    chk("t1_count_after_push",   32'(ifa.fifo_count), 32'd1);
    chk("t1_busy_after_push",    32'(ifa.tx_busy),    32'd0);
    idle(1);
    chk("t1_tx_start",  32'(ifa.tx),         32'd0);
    chk("t1_busy_set",  32'(ifa.tx_busy),    32'd1);
    chk("t1_count_pop", 32'(ifa.fifo_count), 32'd0);
    bn = 0; fn = 0; fpos = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (ifa.tx_busy === 1'b1) bn++;
      if (ifa.frame_done === 1'b1) begin
        fn++;
        fpos = i;
      end
    end
    @(posedge clk);
    #1;
    chk("t1_busy_cycles", 32'(bn),   32'd40);
    chk("t1_fdone_count", 32'(fn),   32'd1);
    chk("t1_fdone_pos",   32'(fpos), 32'd40);
    drain("t1_drain", 200);

    // 2) two back-to-back frames
    start_a.delete();
    fd0 = fd_a;
    step_a(8'h01);
    exp_a.push_back(8'h01);
    chk("t2_count_first", 32'(ifa.fifo_count), 32'd1);
    step_a(8'h80);
    exp_a.push_back(8'h80);
    chk("t2_count_pushpop", 32'(ifa.fifo_count), 32'd1);
    chk("t2_tx_start",      32'(ifa.tx),         32'd0);
    idle(39);
    chk("t2_fdone_first",   32'(ifa.frame_done), 32'd1);
    chk("t2_count_before",  32'(ifa.fifo_count), 32'd1);
    idle(1);
    chk("t2_count_after",   32'(ifa.fifo_count), 32'd0);
    chk("t2_tx_second",     32'(ifa.tx),         32'd0);
    chk("t2_busy_second",   32'(ifa.tx_busy),    32'd1);
    drain("t2_drain", 200);
    chk("t2_frames", 32'(start_a.size()), 32'd2);
    if (start_a.size() >= 2) chk("t2_contiguous", 32'(start_a[1] - start_a[0]), 32'd40);
    chk("t2_fdone_total", 32'(fd_a - fd0), 32'd2);

    // 3) six consecutive samples overflow a 4-deep FIFO
    for (int v = 1; v <= 6; v++) begin
      step_a(8'(v));
      if (v <= 5) exp_a.push_back(8'(v));
      if (v == 5) chk("t3_no_overflow_yet", 32'(ifa.overflow), 32'd0);
    end
    chk("t3_overflow_set", 32'(ifa.overflow),   32'd1);
    chk("t3_count_full",   32'(ifa.fifo_count), 32'd4);
    drain("t3_drain", 400);
    chk("t3_overflow_sticky", 32'(ifa.overflow), 32'd1);

    // 4) decimation by 3
    for (int v = 10; v <= 18; v++) begin
      step_b(8'(v));
      if ((v - 10) % 3 == 0) exp_b.push_back(8'(v));
    end
    drain("t4_drain", 300);
    chk("t4_b_overflow", 32'(ifb.overflow), 32'd0);

    // 5) reset mid-frame with entries queued
    step_a(8'hFF);
    step_a(8'h11);
    step_a(8'h22);
    chk("t5_count_queued", 32'(ifa.fifo_count), 32'd2);
    idle(8);
    chk("t5_busy_in_data", 32'(ifa.tx_busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_rst_tx",       32'(ifa.tx),         32'd1);
    chk("t5_rst_count",    32'(ifa.fifo_count), 32'd0);
    chk("t5_rst_busy",     32'(ifa.tx_busy),    32'd0);
    chk("t5_rst_overflow", 32'(ifa.overflow),   32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    low = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (ifa.tx !== 1'b1) low++;
    end
    chk("t5_line_quiet", 32'(low),           32'd0);
    chk("t5_busy_quiet", 32'(ifa.tx_busy),   32'd0);

    // 6) full FIFO, push lands on the STOP-end pop
    step_a(8'h3C); exp_a.push_back(8'h3C);
    step_a(8'hC3); exp_a.push_back(8'hC3);
    step_a(8'h5A); exp_a.push_back(8'h5A);
    step_a(8'h0F); exp_a.push_back(8'h0F);
    step_a(8'hF0); exp_a.push_back(8'hF0);
    chk("t6_count_full", 32'(ifa.fifo_count), 32'd4);
    idle(36);
    chk("t6_fdone",      32'(ifa.frame_done), 32'd1);
    chk("t6_count_full2",32'(ifa.fifo_count), 32'd4);
    step_a(8'h99); exp_a.push_back(8'h99);
    chk("t6_count_pushpop", 32'(ifa.fifo_count), 32'd4);
    chk("t6_no_overflow",   32'(ifa.overflow),   32'd0);
    drain("t6_drain", 400);
    chk("t6_no_overflow_end", 32'(ifa.overflow), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
